// File: rtl/definesPkg.sv
// rtl/definesPkg.sv - shared AHB-Lite encodings, burst helpers and burst-master state type
package definesPkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT0,
        S_BURST,
        S_LAST,
        S_ERR
    } state_t;

    function automatic logic burst_is_wrap(input logic [2:0] burst);
        return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
    endfunction

    // Index of the final beat; undefined-length INCR runs as a single beat.
    function automatic logic [3:0] burst_last_beat(input logic [2:0] burst);
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_burst_master_addr_gen.sv
// rtl/ahb_lite_burst_master_addr_gen.sv - beat count, INCR/WRAP next address and command reject logic
module ahb_burst_addr_gen
    import definesPkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int BOUNDARY_BYTES = 1024
)(
    input  logic [$clog2(BOUNDARY_BYTES)-1:0] i_cmd_ofs,
    input  logic [2:0]                        i_cmd_burst,
    input  logic [ADDR_W-1:0]                 i_addr,
    input  logic [2:0]                        i_burst,
    output logic [3:0]                        o_cmd_last_beat,
    output logic                              o_reject,
    output logic [ADDR_W-1:0]                 o_next_addr
);
    localparam int OFS_W = $clog2(BOUNDARY_BYTES);

    logic [3:0]        w_cmd_last;
    logic [3:0]        w_last;
    logic [OFS_W+1:0]  w_span_end;
    logic [ADDR_W-1:0] w_incr_addr;
    logic [ADDR_W-1:0] w_wrap_mask;

    always_comb begin
        w_cmd_last = burst_last_beat(i_cmd_burst);
        // Byte just past the burst, measured inside the current boundary window.
        w_span_end = {2'b00, i_cmd_ofs}
                   + {{(OFS_W-4){1'b0}}, w_cmd_last, 2'b00}
                   + (OFS_W+2)'(4);
        o_cmd_last_beat = w_cmd_last;
        o_reject = (i_cmd_ofs[1:0] != 2'b00)
                || (!burst_is_wrap(i_cmd_burst) && (w_span_end > (OFS_W+2)'(BOUNDARY_BYTES)));

        w_last      = burst_last_beat(i_burst);
        w_incr_addr = i_addr + ADDR_W'(4);
        w_wrap_mask = {{(ADDR_W-6){1'b0}}, w_last, 2'b11};
        o_next_addr = burst_is_wrap(i_burst)
                    ? ((i_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask))
                    : w_incr_addr;
    end

endmodule

// File: rtl/ahb_lite_burst_master.sv
// rtl/ahb_lite_burst_master.sv - AHB-Lite initiator issuing SINGLE/INCRn/WRAPn word bursts from a command port
module ahb_lite_burst_master
    import definesPkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int BOUNDARY_BYTES = 1024
)(
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_burst,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              done,
    output logic              done_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [1:0]        HTRANS,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);
    localparam int OFS_W = $clog2(BOUNDARY_BYTES);

    state_t            r_state, w_next_state;
    htrans_t           w_htrans;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [2:0]        r_burst;
    logic [3:0]        r_beat, r_last_beat;
    logic              r_dp_valid, r_dp_read, r_dp_last;
    logic [DATA_W-1:0] r_hwdata, r_rdata;
    logic              r_rdata_valid, r_rdata_last, r_done, r_done_err;
    logic              w_accept, w_reject, w_addr_done, w_dp_err;
    logic [3:0]        w_cmd_last_beat;
    logic [ADDR_W-1:0] w_next_addr;

    ahb_burst_addr_gen #(
        .ADDR_W         (ADDR_W),
        .BOUNDARY_BYTES (BOUNDARY_BYTES)
    ) u_addr_gen (
        .i_cmd_ofs       (cmd_addr[OFS_W-1:0]),
        .i_cmd_burst     (cmd_burst),
        .i_addr          (r_addr),
        .i_burst         (r_burst),
        .o_cmd_last_beat (w_cmd_last_beat),
        .o_reject        (w_reject),
        .o_next_addr     (w_next_addr)
    );

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_dp_err    = r_dp_valid && HRESP && !HREADY;
    assign w_addr_done = HREADY && ((w_htrans == HTRANS_NONSEQ) || (w_htrans == HTRANS_SEQ));

    always_comb begin
        w_htrans = HTRANS_IDLE;
        if (r_state == S_BURST) begin
            if (r_beat == 4'd0)
                w_htrans = HTRANS_NONSEQ;
            else if (r_write && !wdata_valid)
                w_htrans = HTRANS_BUSY;
            else
                w_htrans = HTRANS_SEQ;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // A write whose first beat is already offered skips the IDLE wait cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_reject)
                         w_next_state = (cmd_write && !wdata_valid) ? S_WAIT0 : S_BURST;
            S_WAIT0: if (wdata_valid) w_next_state = S_BURST;
            S_BURST: begin
                if (w_dp_err)
                    w_next_state = S_ERR;
                else if (w_addr_done && (r_beat == r_last_beat))
                    w_next_state = S_LAST;
            end
            S_LAST: begin
                if (w_dp_err)
                    w_next_state = S_ERR;
                else if (HREADY)
                    w_next_state = S_IDLE;
            end
            S_ERR:   if (HREADY) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_burst       <= HBURST_SINGLE;
            r_beat        <= 4'd0;
            r_last_beat   <= 4'd0;
            r_dp_valid    <= 1'b0;
            r_dp_read     <= 1'b0;
            r_dp_last     <= 1'b0;
            r_hwdata      <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
            r_done        <= 1'b0;
            r_done_err    <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
            r_done        <= 1'b0;
            r_done_err    <= 1'b0;

            if (w_accept) begin
                r_addr      <= cmd_addr;
                r_write     <= cmd_write;
                r_burst     <= cmd_burst;
                r_beat      <= 4'd0;
                r_last_beat <= w_cmd_last_beat;
                if (w_reject) begin
                    r_done     <= 1'b1;
                    r_done_err <= 1'b1;
                end
            end

            if (w_addr_done) begin
                r_beat <= r_beat + 4'd1;
                if (r_beat != r_last_beat)
                    r_addr <= w_next_addr;
                if (r_write)
                    r_hwdata <= wdata;
            end

            if (w_addr_done) begin
                r_dp_valid <= 1'b1;
                r_dp_read  <= !r_write;
                r_dp_last  <= (r_beat == r_last_beat);
            end else if (HREADY) begin
                r_dp_valid <= 1'b0;
            end

            if (r_dp_valid && HREADY && !HRESP && r_dp_read) begin
                r_rdata_valid <= 1'b1;
                r_rdata       <= HRDATA;
                r_rdata_last  <= r_dp_last;
            end

            if (HREADY && ((r_state == S_LAST) || (r_state == S_ERR))) begin
                r_done     <= 1'b1;
                r_done_err <= (r_state == S_ERR);
            end
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign wdata_ready = w_addr_done && r_write;
    assign rdata_valid = r_rdata_valid;
    assign rdata       = r_rdata;
    assign rdata_last  = r_rdata_last;
    assign done        = r_done;
    assign done_err    = r_done_err;
    assign HADDR       = r_addr;
    assign HWRITE      = r_write;
    assign HSIZE       = HSIZE_WORD;
    assign HBURST      = r_burst;
    assign HTRANS      = w_htrans;
    assign HWDATA      = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// tb/tb_ahb_lite_burst_master.sv - randomized self-checking bench with slave and burst reference model
module tb_ahb_lite_burst_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_burst = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [31:0] wdata = '0;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        rdata_last, done, done_err;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [31:0]];

    always #5 HCLK = ~HCLK;

    ahb_lite_burst_master #(.ADDR_W(32), .DATA_W(32), .BOUNDARY_BYTES(1024)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_burst(cmd_burst),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
        .done(done), .done_err(done_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic int exp_beats(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    // One command end to end: bench plays the slave and the write-data source.
    task automatic run_cmd(input logic [31:0] a, input logic w, input logic [2:0] b,
                           input int err_beat, input int ws_pct, input int gap_pct, input int abort_at);
        int n, exp_naddr, exp_nrd, naddr, nrd, nwr, widx, acc_cyc, done_cyc, dp_ws, err_ph, span;
        bit wrap, rej, exp_err, dp, dp_err, consumed, got_done, got_err;
        logic [31:0] dp_a, base;
        logic [31:0] exp_addr[$];
        logic [31:0] wdat[$];

        n = exp_beats(b);
        wrap = (b == 3'd2) || (b == 3'd4) || (b == 3'd6);
        rej = (a % 4 != 0) || (!wrap && (a % 1024) + 4 * n > 1024);
        span = 4 * n;
        base = a - (a % span);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(wrap ? base + ((a - base + 4 * i) % span) : a + 4 * i);
            wdat.push_back($urandom);
        end
        exp_err   = rej || (err_beat >= 0);
        exp_naddr = rej ? 0 : (err_beat >= 0 ? err_beat + 1 : n);
        exp_nrd   = (w || rej) ? 0 : (err_beat >= 0 ? err_beat : n);
        naddr = 0; nrd = 0; nwr = 0; widx = 0; acc_cyc = -1; done_cyc = -1;
        dp = 0; dp_err = 0; dp_ws = 0; err_ph = 0; dp_a = '0; consumed = 0; got_done = 0; got_err = 0;

        for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
            @(posedge HCLK); #1;
            if (abort_at > 0 && cyc == abort_at) begin
                HRESETn = 1'b0;
                #1 check("rst_htrans_idle", HTRANS, 0);
                repeat (2) begin @(negedge HCLK); check("rst_no_done", done, 0); end
                @(posedge HCLK); #1;
                HRESETn = 1'b1; wdata_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
                @(negedge HCLK); check("rst_no_done_after", done, 0);
                return;
            end
            cmd_valid = (cyc == 0);
            if (cyc == 0) begin
                cmd_addr = a; cmd_write = w; cmd_burst = b; wdata_valid = 1'b0;
            end
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
            if (dp) begin
                if (dp_err) begin HREADY = (err_ph == 1); HRESP = 1'b1; end
                else begin HREADY = (dp_ws == 0); HRDATA = mem_rd(dp_a); end
            end
            if (consumed) begin wdata_valid = 1'b0; consumed = 0; end
            if (w && !wdata_valid && widx < n && $urandom_range(99) >= gap_pct) begin
                wdata_valid = 1'b1; wdata = wdat[widx];
            end

            @(negedge HCLK);
            if (cyc == 0) begin
                check("cmd_ready_idle", cmd_ready, 1);
                if (cmd_ready) acc_cyc = 0;
            end
            if (cyc == 1 && !rej) check("cmd_ready_busy", cmd_ready, 0);
            if (dp && !HREADY) begin
                if (dp_err) err_ph = 1; else dp_ws--;
            end else if (dp && HREADY) begin
                if (dp_err) check("err_cycle2_idle", HTRANS, 0);
                else if (w) mem[dp_a] = HWDATA;
                dp = 0;
            end
            if (HTRANS == 2'd1 && naddr < n) check("busy_haddr", HADDR, exp_addr[naddr]);
            if (HREADY && (HTRANS == 2'd2 || HTRANS == 2'd3)) begin
                if (naddr < exp_naddr) check("haddr", HADDR, exp_addr[naddr]);
                else check("extra_addr_phase", naddr + 1, exp_naddr);
                check("htrans_kind", HTRANS, (naddr == 0) ? 2 : 3);
                check("hwrite", HWRITE, w);
                check("hburst", HBURST, b);
                check("hsize", HSIZE, 2);
                dp = 1; dp_a = HADDR; dp_err = (naddr == err_beat); err_ph = 0;
                dp_ws = (!dp_err && $urandom_range(99) < ws_pct) ? $urandom_range(1, 2) : 0;
                naddr++;
            end
            if (wdata_ready) begin
                check("wdata_valid_at_ready", wdata_valid, 1);
                nwr++; widx++; consumed = 1;
            end
            if (rdata_valid) begin
                if (nrd < n) begin
                    check("rdata", rdata, mem_rd(exp_addr[nrd]));
                    check("rdata_last", rdata_last, nrd == n - 1);
                end
                nrd++;
            end
            if (done) begin got_done = 1; got_err = done_err; done_cyc = cyc; end
        end
        cmd_valid = 1'b0;

        check("done_seen", got_done, 1);
        check("done_err", got_err, exp_err);
        check("addr_phases", naddr, exp_naddr);
        check("rdata_beats", nrd, exp_nrd);
        check("wdata_beats", nwr, w ? exp_naddr : 0);
        if (rej) check("reject_latency", done_cyc - acc_cyc, 1);
        if (w && !exp_err)
            for (int i = 0; i < n; i++) check("mem_written", mem_rd(exp_addr[i]), wdat[i]);
        if (!got_done) begin
            @(posedge HCLK); #1 HRESETn = 1'b0;
            @(posedge HCLK); #1 HRESETn = 1'b1;
        end
    endtask

    initial begin
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_htrans", HTRANS, 0);
        check("rst_haddr", HADDR, 0);
        check("rst_hwrite", HWRITE, 0);
        check("rst_hburst", HBURST, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_hsize", HSIZE, 2);
        check("rst_done", done, 0);
        check("rst_done_err", done_err, 0);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_rdata_last", rdata_last, 0);
        check("rst_wdata_ready", wdata_ready, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge HCLK); #1 HRESETn = 1'b1;

        // SINGLE write, exact cycle timing with zero wait states.
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_write = 1'b1; cmd_burst = 3'd0;
        wdata_valid = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        @(negedge HCLK);
        check("sw_c1_htrans", HTRANS, 2);
        check("sw_c1_haddr", HADDR, 32'h10);
        check("sw_c1_hwrite", HWRITE, 1);
        check("sw_c1_wdata_ready", wdata_ready, 1);
        @(posedge HCLK); #1 wdata_valid = 1'b0;
        @(negedge HCLK);
        check("sw_c2_htrans", HTRANS, 0);
        check("sw_c2_hwdata", HWDATA, 32'hDEADBEEF);
        check("sw_c2_done", done, 0);
        @(negedge HCLK);
        check("sw_c3_done", done, 1);
        check("sw_c3_done_err", done_err, 0);

        run_cmd(32'h100, 1'b0, 3'd3, -1, 40, 0, 0);
        run_cmd(32'h03C, 1'b1, 3'd4, -1, 0, 0, 0);
        run_cmd(32'h200, 1'b1, 3'd5, -1, 0, 50, 0);
        run_cmd(32'h3F0, 1'b0, 3'd7, -1, 0, 0, 0);
        run_cmd(32'h102, 1'b1, 3'd0, -1, 0, 0, 0);
        run_cmd(32'h3C0, 1'b0, 3'd7, -1, 20, 0, 0);
        run_cmd(32'h000, 1'b1, 3'd3, 1, 0, 0, 0);
        run_cmd(32'h040, 1'b0, 3'd6, 5, 30, 0, 0);
        run_cmd(32'h000, 1'b0, 3'd7, -1, 0, 0, 3);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            logic [2:0]  rb;
            int          re;
            ra = $urandom_range(0, 1023) * 4;
            if ($urandom_range(9) == 0) ra = ra + $urandom_range(1, 3);
            rb = 3'($urandom_range(7));
            re = ($urandom_range(5) == 0) ? $urandom_range(exp_beats(rb) - 1) : -1;
            run_cmd(ra, 1'($urandom_range(1)), rb, re, 30, 30, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
